// File: rtl/counter_readback_if.sv
// Byte-stream handshake between the counter readback block and its consumer.
// The readback block is the master: it presents the FIFO head with tx_valid and
// tx_data, and the consumer accepts the head with tx_ready.
interface counter_readback_if #(
  parameter int WIDTH = 8
) ();

  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );

endinterface

// File: rtl/counter_readback.sv
// Counter readback: snapshots the programmable counter's count bus on an
// edge of the asynchronous cap_req pin, queues the snapshots in a small
// show-ahead FIFO and streams them out over a valid/ready handshake.
// Sticky status: wrap_flag (count went MAX -> 0) and overflow (capture
// dropped because the FIFO was full).
//
// Optional build macro READBACK_DELTA_EN: when defined, each queued entry is
// the distance from the previously accepted snapshot instead of the absolute
// count (base register starts at 0, so the first entry is absolute).
module counter_readback #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     cap_req,
  input  logic                     clr_flags,
  counter_readback_if.master       tx,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     wrap_flag,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("counter_readback: DEPTH must be a power of two and at least 2");
  end

  // Distance between two counter samples, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] count_delta(
    input logic [WIDTH-1:0] now_val,
    input logic [WIDTH-1:0] ref_val
  );
    return now_val - ref_val;
  endfunction

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_prev;

  logic             cap_sync_p0;
  logic             cap_sync_p1;
  logic             cap_prev_p2;
  logic             cap_pulse;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             full;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;
  logic             wrap_hit;
  logic [WIDTH-1:0] push_data;

  // ---- stage: count bus sampling ----
  // Register the count bus and keep one cycle of history for wrap detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      count_prev <= '0;
    end else begin
      count_q    <= count_in;
      count_prev <= count_q;
    end
  end

  // ---- stage: capture request synchronizer and edge detector ----
  // Two flops tame the asynchronous pin; the third remembers the previous
  // synchronized level so a held-high request yields one pulse only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_sync_p0 <= 1'b0;
      cap_sync_p1 <= 1'b0;
      cap_prev_p2 <= 1'b0;
    end else begin
      cap_sync_p0 <= cap_req;
      cap_sync_p1 <= cap_sync_p0;
      cap_prev_p2 <= cap_sync_p1;
    end
  end

  // The detector runs regardless of ena, so an edge seen while disabled is lost.
  assign cap_pulse = cap_sync_p1 & ~cap_prev_p2;

  // ---- stage: FIFO control ----
  assign full     = (fifo_level == LVL_W'(DEPTH));
  assign pop      = tx.tx_valid & tx.tx_ready;
  assign push_req = cap_pulse & ena;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign wrap_hit = ena & (count_prev == {WIDTH{1'b1}}) & (count_q == '0);

`ifdef READBACK_DELTA_EN
  logic [WIDTH-1:0] base;

  // Remember the last accepted snapshot; dropped captures leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base <= '0;
    end else if (push) begin
      base <= count_q;
    end
  end

  assign push_data = count_delta(count_q, base);
`else
  assign push_data = count_q;
`endif

  // Snapshot storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Read/write pointers, wrapping modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_level <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---- stage: sticky status ----
  // A set event in the same cycle as clr_flags wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_flag <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wrap_hit) begin
        wrap_flag <= 1'b1;
      end else if (clr_flags) begin
        wrap_flag <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
    end
  end

  // Show-ahead output: head entry is visible whenever the FIFO holds data.
  assign tx.tx_valid = (fifo_level != '0);
  assign tx.tx_data  = mem[rd_ptr];

endmodule

// File: tb/tb_counter_readback.sv
// Directed bench for counter_readback: a per-cycle vector table for capture
// latency and wrap/clear behaviour, followed by hand-written multi-cycle
// sequences for FIFO overflow, simultaneous push/pop, level-held requests,
// the delta build option and reset during a transfer.
module tb_counter_readback;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] count_in;
  logic       cap_req;
  logic       clr_flags;
  logic [2:0] fifo_level;
  logic       wrap_flag;
  logic       overflow;

  counter_readback_if #(.WIDTH(8)) bus ();

  counter_readback #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .count_in   (count_in),
    .cap_req    (cap_req),
    .clr_flags  (clr_flags),
    .tx         (bus),
    .fifo_level (fifo_level),
    .wrap_flag  (wrap_flag),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference queue of expected FIFO contents and the model's delta base.
  logic [7:0] exp_q[$];
  logic [7:0] m_base;

  typedef struct {
    logic       ena;
    logic [7:0] cnt;
    logic       cap;
    logic       clr;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_level;
    logic       e_wrap;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic e, input logic [7:0] c, input logic cp,
                              input logic cl, input logic r, input logic ev,
                              input logic [7:0] ed, input logic [2:0] el,
                              input logic ew, input logic eo);
    vec_t v;
    v.ena = e; v.cnt = c; v.cap = cp; v.clr = cl; v.rdy = r;
    v.e_valid = ev; v.e_data = ed; v.e_level = el; v.e_wrap = ew; v.e_ovf = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of one capture: accepted entries go into the reference queue.
  task automatic model_push(input logic [7:0] v, input logic accepted);
    logic [7:0] e;
`ifdef READBACK_DELTA_EN
    e = v - m_base;
`else
    e = v;
`endif
    if (accepted) begin
      exp_q.push_back(e);
      m_base = v;
    end
  endtask

  task automatic reset_dut();
    ena = 1'b1; count_in = 8'h00; cap_req = 1'b0; clr_flags = 1'b0; bus.tx_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    check("rst_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_data",  32'(bus.tx_data),  32'd0);
    check("rst_level", 32'(fifo_level),   32'd0);
    check("rst_wrap",  32'(wrap_flag),    32'd0);
    check("rst_ovf",   32'(overflow),     32'd0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    m_base = 8'h00;
  endtask

  // Present v on the count bus, pulse cap_req for one cycle and advance to the
  // push edge; rdy_at_push asserts tx_ready only for that edge.
  task automatic capture(input logic [7:0] v, input logic rdy_at_push);
    count_in = v;
    tick();
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    tick();
    bus.tx_ready = rdy_at_push;
    tick();
    bus.tx_ready = 1'b0;
  endtask

  // Pop n entries, comparing each head against the reference queue.
  task automatic drain(input int n, input string tag);
    logic [7:0] e;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      check({tag, "_valid"}, 32'(bus.tx_valid), 32'd1);
      check({tag, "_data"},  32'(bus.tx_data),  32'(e));
      tick();
    end
    bus.tx_ready = 1'b0;
    check({tag, "_empty_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_empty_level"}, 32'(fifo_level),   32'd0);
  endtask

  initial begin
    logic [7:0] delta_exp [3];
    logic [7:0] e;

    // Capture latency, pop, wrap detection, clear and clear-vs-set priority.
    vecs[0]  = mk(1, 8'h2A, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[1]  = mk(1, 8'h2A, 1, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[2]  = mk(1, 8'h2A, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[3]  = mk(1, 8'h2A, 0, 0, 0,  1, 8'h2A, 3'd1, 0, 0);
    vecs[4]  = mk(1, 8'h2A, 0, 0, 1,  0, 8'h00, 3'd0, 0, 0);
    vecs[5]  = mk(1, 8'hFE, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[6]  = mk(1, 8'hFF, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[7]  = mk(1, 8'h00, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[8]  = mk(1, 8'h00, 0, 0, 0,  0, 8'h00, 3'd0, 1, 0);
    vecs[9]  = mk(1, 8'h00, 0, 1, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[10] = mk(1, 8'h00, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[11] = mk(0, 8'hFE, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[12] = mk(0, 8'hFF, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[13] = mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[14] = mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[15] = mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[16] = mk(1, 8'hFF, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[17] = mk(1, 8'h00, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[18] = mk(1, 8'h00, 0, 1, 0,  0, 8'h00, 3'd0, 1, 0);
    vecs[19] = mk(1, 8'h00, 0, 1, 0,  0, 8'h00, 3'd0, 0, 0);
    vecs[20] = mk(1, 8'h00, 0, 0, 0,  0, 8'h00, 3'd0, 0, 0);

    reset_dut();
    for (int i = 0; i < 21; i++) begin
      ena = vecs[i].ena; count_in = vecs[i].cnt; cap_req = vecs[i].cap;
      clr_flags = vecs[i].clr; bus.tx_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(bus.tx_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_level", i), 32'(fifo_level),   32'(vecs[i].e_level));
      check($sformatf("vec%0d_wrap",  i), 32'(wrap_flag),    32'(vecs[i].e_wrap));
      check($sformatf("vec%0d_ovf",   i), 32'(overflow),     32'(vecs[i].e_ovf));
      if (vecs[i].e_valid)
        check($sformatf("vec%0d_data", i), 32'(bus.tx_data), 32'(vecs[i].e_data));
    end
    ena = 1'b1; clr_flags = 1'b0; bus.tx_ready = 1'b0; cap_req = 1'b0;

    // Fill to DEPTH, then one more capture is dropped and sets overflow.
    reset_dut();
    for (int v = 1; v <= 4; v++) begin
      capture(8'(v), 1'b0);
      model_push(8'(v), 1'b1);
    end
    check("fill_level", 32'(fifo_level), 32'd4);
    check("fill_ovf",   32'(overflow),   32'd0);
    capture(8'd5, 1'b0);
    model_push(8'd5, 1'b0);
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag",  32'(overflow),   32'd1);
    check("ovf_head",  32'(bus.tx_data), 32'(exp_q[0]));
    drain(4, "ovf_drain");

    // Clear overflow, refill, then push while popping on a full FIFO.
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    for (int v = 5; v <= 8; v++) begin
      capture(8'(v), 1'b0);
      model_push(8'(v), 1'b1);
    end
    check("full2_level", 32'(fifo_level), 32'd4);
    check("full2_head", 32'(bus.tx_data), 32'(exp_q[0]));
    capture(8'd9, 1'b1);
    e = exp_q.pop_front();
    model_push(8'd9, 1'b1);
    check("fullpp_level", 32'(fifo_level), 32'd4);
    check("fullpp_ovf",   32'(overflow),   32'd0);
    drain(4, "fullpp_drain");

    // Push into empty with tx_ready high: no pop; then push+pop at level 1.
    capture(8'd10, 1'b1);
    model_push(8'd10, 1'b1);
    check("empty_rdy_level", 32'(fifo_level), 32'd1);
    check("empty_rdy_data",  32'(bus.tx_data), 32'(exp_q[0]));
    capture(8'd11, 1'b1);
    e = exp_q.pop_front();
    model_push(8'd11, 1'b1);
    check("lvl1_pp_level", 32'(fifo_level), 32'd1);
    drain(1, "lvl1_drain");

    // A request held high for ten cycles gives exactly one entry.
    count_in = 8'h33;
    cap_req = 1'b1;
    repeat (10) tick();
    cap_req = 1'b0;
    repeat (3) tick();
    model_push(8'h33, 1'b1);
    check("hold_level", 32'(fifo_level), 32'd1);
    drain(1, "hold_drain");

    // The same held request whose edge falls while disabled gives nothing.
    ena = 1'b0;
    cap_req = 1'b1;
    repeat (10) tick();
    ena = 1'b1;
    repeat (3) tick();
    cap_req = 1'b0;
    repeat (3) tick();
    check("hold_dis_level", 32'(fifo_level), 32'd0);

    // Absolute vs delta entries for captures at 10, 25, 3.
    reset_dut();
`ifdef READBACK_DELTA_EN
    delta_exp[0] = 8'd10; delta_exp[1] = 8'd15; delta_exp[2] = 8'hEA;
`else
    delta_exp[0] = 8'd10; delta_exp[1] = 8'd25; delta_exp[2] = 8'd3;
`endif
    capture(8'd10, 1'b0);
    capture(8'd25, 1'b0);
    capture(8'd3,  1'b0);
    check("delta_level", 32'(fifo_level), 32'd3);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("delta_data%0d", i), 32'(bus.tx_data), 32'(delta_exp[i]));
      tick();
    end
    bus.tx_ready = 1'b0;

    // Asynchronous reset while an entry is waiting.
    capture(8'h77, 1'b0);
    check("midrst_pre_valid", 32'(bus.tx_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.tx_valid), 32'd0);
    check("midrst_level", 32'(fifo_level),   32'd0);
    check("midrst_data",  32'(bus.tx_data),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
